p09_sprite_renderer: RTL and testbench
======================================

# p09_sprite_renderer

Pixel-generation stage directly downstream of the sprite movement block. Takes the current sprite position (`sprite_x`, `sprite_y`, in scaled-down coordinates) and the VGA timing counters. Emits a registered per-pixel `sprite_pixel` flag for the colour mux. Also produces the `next_frame` pulse that the movement block consumes, and holds the sprite bitmap, which is loaded serially.

## Interface
Parameters:
- `SPRITE_WIDTH`, 8, sprite width in small pixels
- `SPRITE_HEIGHT`, 8, sprite height in small pixels
- `SCALE_SHIFT`, 2, log2 of the screen-to-small scale factor (2 → 4×4 screen pixels per small pixel)
- `HEIGHT`, 480, visible lines; `next_frame` fires at line `HEIGHT`

Ports:
- `clk`  in  1  pixel clock
- `reset_n`  in  1  reset, synchronous, active-low
- `counter_h`  in  10  horizontal pixel counter from timing generator
- `counter_v`  in  10  vertical line counter from timing generator
- `display_on`  in  1  high in visible area
- `sprite_x`  in  8  sprite left edge, small coords
- `sprite_y`  in  8  sprite top edge, small coords
- `shift_sprite`  in  1  shift one bitmap bit in
- `data_in_sprite`  in  1  bitmap bit
- `next_frame`  out  1  one-cycle pulse, start of vertical blank
- `sprite_pixel`  out  1  sprite pixel is set at delayed position

## Operation
- Reset (synchronous, `reset_n` low at a `clk` edge): bitmap(s) zero, pipeline registers zero, `sprite_pixel`=0, `next_frame`=0.
- Bitmap: N = `SPRITE_WIDTH`*`SPRITE_HEIGHT` bits.
  - On `shift_sprite`: bitmap ← {bitmap[N-2:0], `data_in_sprite`}.
  - The first bit shifted of the last N is the top-left pixel, in row-major order.
  - Pixel (rx, ry) = bitmap[N-1 − (ry*`SPRITE_WIDTH`+rx)].
- Stage 1 (registered):
  - xs = `counter_h` >> `SCALE_SHIFT`; ys = `counter_v` >> `SCALE_SHIFT`.
  - Both are zero-extended, then truncated to 8 bits.
  - rx = xs − `sprite_x`, ry = ys − `sprite_y`, computed 9-bit.
  - in_box = (xs ≥ `sprite_x`) && (rx < `SPRITE_WIDTH`) && (ys ≥ `sprite_y`) && (ry < `SPRITE_HEIGHT`).
  - No wrap-around: a sprite near coordinate 255 is clipped, never drawn at 0.
  - Register `display_on` alongside.
- Stage 2 (registered): `sprite_pixel` = in_box_d && display_on_d && bitmap bit(rx_d, ry_d).
- Bitmap index is computed from stage-1 registers only; no multiplier on the stage-1 path.
- `next_frame`: registered pulse, high for exactly one cycle after the cycle where `counter_v`==`HEIGHT` && `counter_h`==0.
- Position inputs are sampled every cycle. A change mid-frame takes effect on the next sampled pixel; tearing is acceptable for position.

## Timing
- `sprite_pixel` latency: 2 cycles from `counter_h`/`counter_v`/`display_on`/`sprite_*`. The colour mux delays the other sources by 2 to match.
- `next_frame` latency: 1 cycle after the matching counter values; never asserted twice per frame.
- Bitmap shift:
  - Visible to rendering the cycle after the shift edge (no macro).
  - Visible at the next `next_frame` commit (with macro).
- Reset asserted mid-frame: outputs 0 from the next edge. Rendering resumes 2 cycles after release, with an all-zero bitmap.

## Configuration
- `SPRITE_DOUBLE_BUFFER_EN` defined:
  - `shift_sprite` writes a shadow bitmap.
  - Active bitmap ← shadow on the cycle `next_frame` is high.
  - Shift and commit in the same cycle: active takes the shadow's pre-shift value, and the shadow shifts.
  - Guarantees no tearing of bitmap content within a frame.
- Not defined: single bitmap, shifted directly; rendering may tear during loading.

## Structure
- Shared package `p09_pkg`:
  - `SCREEN_HEIGHT`, `SCALE_SHIFT`, `SPRITE_WIDTH`, `SPRITE_HEIGHT` constants.
  - `sprite_bitmap_t` typedef (logic [N-1:0]).
- One sub-module: `p09_sprite_bitmap`, holding the serial-load register(s) and the optional double buffer behind the macro. It exposes the active bitmap vector.
- Hit test and pipeline stay in the top.

## Test plan
- Reset, then shift 64 ones, sprite at (10,20), sweep `counter_h`=40..71, `counter_v`=80, `display_on`=1 → `sprite_pixel`=1 exactly for h 40..71, each 2 cycles later; 0 at h 39 and h 72.
- Bitmap with only the top-left bit set (1 then 63 zeros), sprite (0,0) → pixel 1 only for h 0..3, v 0..3; `display_on`=0 at the same counters → 0.
- Sprite at (252,0), width 8 → pixels for xs 252..255 only; xs 0..3 stay 0 (no wrap).
- Counters step through line 479→480, h=0 → `next_frame` high for exactly one cycle, once per frame.
- With `SPRITE_DOUBLE_BUFFER_EN`, shift a new pattern mid-frame → rendering keeps the old pattern until `next_frame`, the new pattern appears after. Without the macro → new bits render the next cycle.
- Assert `reset_n`=0 for one cycle mid-sprite → `sprite_pixel`=0 from the next edge; bitmap cleared; `next_frame` not spuriously pulsed.

Source files
------------

// File: rtl/p09_pkg.sv
// Shared constants and types for the p09 sprite renderer slice.
// The optional bitmap double buffer is enabled by defining SPRITE_DOUBLE_BUFFER_EN.
package p09_pkg;
  localparam int SCREEN_HEIGHT = 480;
  localparam int SCALE_SHIFT   = 2;
  localparam int SPRITE_WIDTH  = 8;
  localparam int SPRITE_HEIGHT = 8;
  localparam int SPRITE_N      = SPRITE_WIDTH * SPRITE_HEIGHT;

  typedef logic [SPRITE_N-1:0] sprite_bitmap_t;
endpackage

// File: rtl/p09_sprite_bitmap.sv
// Serially loaded sprite bitmap; SPRITE_DOUBLE_BUFFER_EN adds a shadow register
// that is copied to the active bitmap only when commit_i (next_frame) is high.
module p09_sprite_bitmap
  import p09_pkg::*;
#(
  parameter int N = SPRITE_N
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         shift_i,
  input  logic         data_i,
  input  logic         commit_i,
  output logic [N-1:0] bitmap_o
);

`ifdef SPRITE_DOUBLE_BUFFER_EN
  logic [N-1:0] shadow_q, shadow_d;
  logic [N-1:0] active_q, active_d;

  // Shadow takes new bits; active copies the shadow's pre-shift value on commit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (shift_i) begin
      shadow_d = {shadow_q[N-2:0], data_i};
    end else begin
      shadow_d = shadow_q;
    end
    if (commit_i) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
  end

  // Bitmap registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign bitmap_o = active_q;
`else
  logic [N-1:0] bitmap_q, bitmap_d;
  logic         unused_commit_s;

  assign unused_commit_s = commit_i;

  // Single bitmap shifts in place; rendering may tear while loading.
  always_comb begin
    bitmap_d = bitmap_q;
    if (shift_i) begin
      bitmap_d = {bitmap_q[N-2:0], data_i};
    end else begin
      bitmap_d = bitmap_q;
    end
  end

  // Bitmap register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bitmap_q <= '0;
    end else begin
      bitmap_q <= bitmap_d;
    end
  end

  assign bitmap_o = bitmap_q;
`endif

endmodule

// File: rtl/p09_sprite_renderer.sv
// Two-stage sprite hit test and bitmap lookup, plus the next_frame pulse.
// Optional SPRITE_DOUBLE_BUFFER_EN makes bitmap loads take effect at next_frame.
module p09_sprite_renderer #(
  parameter int SPRITE_WIDTH  = p09_pkg::SPRITE_WIDTH,
  parameter int SPRITE_HEIGHT = p09_pkg::SPRITE_HEIGHT,
  parameter int SCALE_SHIFT   = p09_pkg::SCALE_SHIFT,
  parameter int HEIGHT        = p09_pkg::SCREEN_HEIGHT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] counter_h,
  input  logic [9:0] counter_v,
  input  logic       display_on,
  input  logic [7:0] sprite_x,
  input  logic [7:0] sprite_y,
  input  logic       shift_sprite,
  input  logic       data_in_sprite,
  output logic       next_frame,
  output logic       sprite_pixel
);
  import p09_pkg::*;

  localparam int N    = SPRITE_WIDTH * SPRITE_HEIGHT;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int RXW  = (SPRITE_WIDTH > 1) ? $clog2(SPRITE_WIDTH) : 1;
  localparam int RYW  = (SPRITE_HEIGHT > 1) ? $clog2(SPRITE_HEIGHT) : 1;

  logic [N-1:0]    bitmap_s;
  logic [7:0]      xs_s, ys_s;
  logic [8:0]      rx_s, ry_s;
  logic            in_box_d, in_box_q;
  logic            disp_d, disp_q;
  logic [RXW-1:0]  rx_d, rx_q;
  logic [RYW-1:0]  ry_d, ry_q;
  logic [IDXW-1:0] lin_s, idx_s;
  logic            pix_d, pix_q;
  logic            nf_d, nf_q;

  p09_sprite_bitmap #(
    .N (N)
  ) u_bitmap (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_i  (shift_sprite),
    .data_i   (data_in_sprite),
    .commit_i (nf_q),
    .bitmap_o (bitmap_s)
  );

  // Stage-1 hit test; the 9-bit difference keeps sprites near 255 from wrapping to 0.
  always_comb begin
    xs_s     = 8'(counter_h >> SCALE_SHIFT);
    ys_s     = 8'(counter_v >> SCALE_SHIFT);
    rx_s     = {1'b0, xs_s} - {1'b0, sprite_x};
    ry_s     = {1'b0, ys_s} - {1'b0, sprite_y};
    in_box_d = (xs_s >= sprite_x) && (rx_s < 9'(SPRITE_WIDTH)) &&
               (ys_s >= sprite_y) && (ry_s < 9'(SPRITE_HEIGHT));
    disp_d   = display_on;
    rx_d     = rx_s[RXW-1:0];
    ry_d     = ry_s[RYW-1:0];
    nf_d     = (counter_v == 10'(HEIGHT)) && (counter_h == 10'd0);
  end

  // Stage-2 bitmap lookup from registered offsets only.
  always_comb begin
    lin_s = IDXW'(ry_q) * IDXW'(SPRITE_WIDTH) + IDXW'(rx_q);
    idx_s = IDXW'(N - 1) - lin_s;
    pix_d = in_box_q && disp_q && bitmap_s[idx_s];
  end

  // Pipeline and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_box_q <= 1'b0;
      disp_q   <= 1'b0;
      rx_q     <= '0;
      ry_q     <= '0;
      pix_q    <= 1'b0;
      nf_q     <= 1'b0;
    end else begin
      in_box_q <= in_box_d;
      disp_q   <= disp_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      pix_q    <= pix_d;
      nf_q     <= nf_d;
    end
  end

  assign sprite_pixel = pix_q;
  assign next_frame   = nf_q;

endmodule

// File: tb/tb_p09_sprite_renderer.sv
// Scoreboard bench for p09_sprite_renderer; reference model works in screen/sprite
// coordinates with a bit queue for the bitmap (top-left pixel at index 0).
module tb_p09_sprite_renderer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] counter_h = 10'd0;
  logic [9:0] counter_v = 10'd0;
  logic       display_on = 1'b0;
  logic [7:0] sprite_x = 8'd0;
  logic [7:0] sprite_y = 8'd0;
  logic       shift_sprite = 1'b0;
  logic       data_in_sprite = 1'b0;
  logic       next_frame;
  logic       sprite_pixel;

  always #5 clk = ~clk;

  p09_sprite_renderer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .counter_h      (counter_h),
    .counter_v      (counter_v),
    .display_on     (display_on),
    .sprite_x       (sprite_x),
    .sprite_y       (sprite_y),
    .shift_sprite   (shift_sprite),
    .data_in_sprite (data_in_sprite),
    .next_frame     (next_frame),
    .sprite_pixel   (sprite_pixel)
  );

  int total = 0;
  int bad = 0;
  int nf_seen = 0;
  bit exp_pix_q[$];
  bit exp_nf_q[$];
  bit act_bits[$];
  bit shadow_bits[$];
  bit commit_pend = 1'b0;

  function automatic void clear_model();
    act_bits.delete();
    shadow_bits.delete();
    for (int i = 0; i < 64; i++) begin
      act_bits.push_back(1'b0);
      shadow_bits.push_back(1'b0);
    end
    commit_pend = 1'b0;
  endfunction

  // One pixel clock of stimulus; the expected responses go to the scoreboard queues.
  task automatic cycle(input int h, input int v, input bit d, input int sx, input int sy,
                       input bit sh, input bit din, input bit rst);
    int xs, ys, rx, ry;
    bit e;
    @(negedge clk);
    counter_h      = 10'(h);
    counter_v      = 10'(v);
    display_on     = d;
    sprite_x       = 8'(sx);
    sprite_y       = 8'(sy);
    shift_sprite   = sh;
    data_in_sprite = din;
    reset_n        = !rst;
    if (rst) begin
      clear_model();
      if (exp_pix_q.size() > 0) exp_pix_q[exp_pix_q.size()-1] = 1'b0;
      exp_pix_q.push_back(1'b0);
      exp_nf_q.push_back(1'b0);
    end else begin
`ifdef SPRITE_DOUBLE_BUFFER_EN
      if (commit_pend) act_bits = shadow_bits;
      if (sh) begin
        shadow_bits.push_back(din);
        void'(shadow_bits.pop_front());
      end
`else
      if (sh) begin
        act_bits.push_back(din);
        void'(act_bits.pop_front());
      end
`endif
      commit_pend = (v == 480) && (h == 0);
      xs = (h / 4) % 256;
      ys = (v / 4) % 256;
      rx = xs - sx;
      ry = ys - sy;
      e = 1'b0;
      if (d && rx >= 0 && rx < 8 && ry >= 0 && ry < 8) e = act_bits[ry*8 + rx];
      exp_pix_q.push_back(e);
      exp_nf_q.push_back(commit_pend);
    end
  endtask

  task automatic load(input logic [63:0] pat);
    for (int i = 0; i < 64; i++) cycle(0, 0, 1'b0, 0, 0, 1'b1, pat[63-i], 1'b0);
  endtask

  task automatic frame_tick();
    cycle(799, 479, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int h = 0; h < 3; h++) cycle(h, 480, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: next_frame lags its inputs by one edge, sprite_pixel by two.
  initial begin
    bit e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_nf_q.size() >= 1) begin
        e = exp_nf_q.pop_front();
        total++;
        if (next_frame !== e) begin
          bad++;
          $display("FAIL next_frame t=%0t got=%b exp=%b", $time, next_frame, e);
        end
        if (next_frame === 1'b1) nf_seen++;
      end
      if (exp_pix_q.size() >= 2) begin
        e = exp_pix_q.pop_front();
        total++;
        if (sprite_pixel !== e) begin
          bad++;
          $display("FAIL sprite_pixel t=%0t h=%0d v=%0d got=%b exp=%b",
                   $time, counter_h, counter_v, sprite_pixel, e);
        end
      end
    end
  end

  initial begin
    int h, v, r, rsx, rsy;
    clear_model();
    for (int i = 0; i < 3; i++) cycle(0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    cycle(0, 0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

    // All-ones sprite at (10,20), sweep across its row on line 80.
    load(64'hFFFF_FFFF_FFFF_FFFF);
    frame_tick();
    for (int hh = 36; hh <= 76; hh++) cycle(hh, 80, 1'b1, 10, 20, 1'b0, 1'b0, 1'b0);

    // Only the top-left pixel set, sprite at origin, with and without display_on.
    load(64'h8000_0000_0000_0000);
    frame_tick();
    for (int dd = 1; dd >= 0; dd--)
      for (int vv = 0; vv < 6; vv++)
        for (int hh = 0; hh < 8; hh++) cycle(hh, vv, bit'(dd), 0, 0, 1'b0, 1'b0, 1'b0);

    // Sprite at the right edge is clipped, never wrapped.
    load(64'hFFFF_FFFF_FFFF_FFFF);
    frame_tick();
    for (int vv = 0; vv < 4; vv++) begin
      for (int hh = 1000; hh < 1024; hh++) cycle(hh, vv, 1'b1, 252, 0, 1'b0, 1'b0, 1'b0);
      for (int hh = 0; hh < 16; hh++) cycle(hh, vv, 1'b1, 252, 0, 1'b0, 1'b0, 1'b0);
    end

    // Frame boundary twice: exactly one pulse per frame.
    nf_seen = 0;
    for (int f = 0; f < 2; f++) begin
      cycle(799, 478, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      cycle(799, 479, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      for (int hh = 0; hh < 6; hh++) cycle(hh, 480, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      cycle(0, 481, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    end
    cycle(0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    cycle(0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (nf_seen != 2) begin
      bad++;
      $display("FAIL frame_pulses got=%0d exp=2", nf_seen);
    end

    // Load a new pattern while rendering, then cross a frame and render again.
    load(64'hFFFF_FFFF_FFFF_FFFF);
    frame_tick();
    for (int i = 0; i < 64; i++)
      cycle(40 + (i % 32), 80 + 4 * (i / 32), 1'b1, 10, 20, 1'b1, bit'((i / 3) % 2), 1'b0);
    frame_tick();
    for (int vv = 80; vv < 112; vv += 4)
      for (int hh = 40; hh < 72; hh++) cycle(hh, vv, 1'b1, 10, 20, 1'b0, 1'b0, 1'b0);

    // One-cycle reset in the middle of the sprite.
    load(64'hFFFF_FFFF_FFFF_FFFF);
    frame_tick();
    for (int hh = 40; hh <= 71; hh++) cycle(hh, 84, 1'b1, 10, 20, 1'b0, 1'b0, hh == 50);
    frame_tick();
    for (int hh = 40; hh <= 50; hh++) cycle(hh, 84, 1'b1, 10, 20, 1'b0, 1'b0, 1'b0);

    // Randomised traffic biased around the sprite.
    rsx = 0;
    rsy = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 50 == 0) begin
        rsx = int'($urandom_range(0, 255));
        rsy = int'($urandom_range(0, 255));
      end
      if (i % 300 == 299) frame_tick();
      if ($urandom_range(0, 3) == 0) begin
        h = int'($urandom_range(0, 1023));
        v = int'($urandom_range(0, 1023));
      end else begin
        r = int'($urandom_range(0, 47));
        h = rsx * 4 + r - 8;
        r = int'($urandom_range(0, 47));
        v = rsy * 4 + r - 8;
      end
      if (h < 0) h = 0;
      if (h > 1023) h = 1023;
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      if ($urandom_range(0, 299) == 0) begin
        h = 0;
        v = 480;
      end
      cycle(h, v, $urandom_range(0, 7) != 0, rsx, rsy, $urandom_range(0, 3) == 0,
            bit'($urandom_range(0, 1)), $urandom_range(0, 499) == 0);
    end

    for (int i = 0; i < 3; i++) cycle(0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
